// File: rtl/memory_arbiter_pkg.sv
// Memory arbiter shared configuration: address map,
// timeout default, FSM states and request bundle.
package memory_arbiter_pkg;

   localparam logic [31:0] BRAM_BASE  = 32'h0000_0000;
   localparam logic [31:0] BRAM_TOP   = 32'h0000_8000;
   localparam logic [31:0] UART_BASE  = 32'h0100_0000;
   localparam logic [31:0] UART_TOP   = 32'h0100_0004;
   localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
   localparam logic [31:0] CLINT_TOP  = 32'h0200_C000;

   localparam int TIMEOUT_DEF = 1024;

   localparam int SL_BRAM  = 0;
   localparam int SL_UART  = 1;
   localparam int SL_CLINT = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_WAIT,
      ST_RESP
   } state_t;

   typedef enum logic {
      PORT_IMEM,
      PORT_DMEM
   } port_t;

   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   function automatic logic in_range(
      input logic [31:0] a,
      input logic [31:0] lo,
      input logic [31:0] hi
   );
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Request, response and slave-side signals of the arbiter.
// slave = arbiter view, master = CPU/slave-device environment.
interface memory_arbiter_if;

   logic        imem_valid;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        imem_error;

   logic        dmem_valid;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        dmem_error;

   logic        bram_valid;
   logic        bram_instr;
   logic [31:0] bram_addr;
   logic [31:0] bram_wdata;
   logic [3:0]  bram_wstrb;
   logic        bram_ready;
   logic [31:0] bram_rdata;

   logic        uart_valid;
   logic        uart_instr;
   logic [31:0] uart_addr;
   logic [31:0] uart_wdata;
   logic [3:0]  uart_wstrb;
   logic        uart_ready;
   logic [31:0] uart_rdata;

   logic        clint_valid;
   logic        clint_instr;
   logic [31:0] clint_addr;
   logic [31:0] clint_wdata;
   logic [3:0]  clint_wstrb;
   logic        clint_ready;
   logic [31:0] clint_rdata;

   modport slave (
      input  imem_valid, imem_addr,
      output imem_ready, imem_rdata, imem_error,
      input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ready, dmem_rdata, dmem_error,
      output bram_valid, bram_instr, bram_addr,
      output bram_wdata, bram_wstrb,
      input  bram_ready, bram_rdata,
      output uart_valid, uart_instr, uart_addr,
      output uart_wdata, uart_wstrb,
      input  uart_ready, uart_rdata,
      output clint_valid, clint_instr, clint_addr,
      output clint_wdata, clint_wstrb,
      input  clint_ready, clint_rdata
   );

   modport master (
      output imem_valid, imem_addr,
      input  imem_ready, imem_rdata, imem_error,
      output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ready, dmem_rdata, dmem_error,
      input  bram_valid, bram_instr, bram_addr,
      input  bram_wdata, bram_wstrb,
      output bram_ready, bram_rdata,
      input  uart_valid, uart_instr, uart_addr,
      input  uart_wdata, uart_wstrb,
      output uart_ready, uart_rdata,
      input  clint_valid, clint_instr, clint_addr,
      input  clint_wdata, clint_wstrb,
      output clint_ready, clint_rdata
   );

endinterface

// File: rtl/memory_arbiter_decode.sv
// Address decoder: one-hot slave select plus offset
// from the selected slave's base.
module arbiter_decode
   import memory_arbiter_pkg::*;
(
   input  logic [31:0] addr,
   output logic [2:0]  hit,
   output logic [31:0] offset
);

   always_comb begin
      hit    = '0;
      offset = '0;
      if (in_range(addr, BRAM_BASE, BRAM_TOP)) begin
         hit[SL_BRAM] = 1'b1;
         offset       = addr - BRAM_BASE;
      end else if (in_range(addr, UART_BASE, UART_TOP)) begin
         hit[SL_UART] = 1'b1;
         offset       = addr - UART_BASE;
      end else if (in_range(addr, CLINT_BASE, CLINT_TOP)) begin
         hit[SL_CLINT] = 1'b1;
         offset        = addr - CLINT_BASE;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Memory arbiter: serializes imem fetch and dmem load/store
// requests onto the bram, uart and clint slaves.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clock,
   input  logic            reset,
   memory_arbiter_if.slave bus
);

   state_t      state;
   logic [1:0]  pend;
   req_t        ireq;
   req_t        dreq;
   req_t        cur;
   req_t        s_req;
   port_t       last;
   port_t       sel;
   port_t       cur_port;
   logic [2:0]  hit;
   logic [2:0]  act;
   logic [31:0] offset;
   logic [31:0] cnt;
   logic [31:0] srdata;
   logic        sready;
   logic        r_ready;
   logic        r_error;
   logic [31:0] r_rdata;
   logic        i_rsp;
   logic        d_rsp;
   logic        tmo;

   // On a tie the port that was not served last wins.
   always_comb begin
      sel = PORT_IMEM;
      if (&pend)
         sel = (last == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
      else if (pend[PORT_DMEM])
         sel = PORT_DMEM;
   end

   assign cur = (sel == PORT_DMEM) ? dreq : ireq;

   arbiter_decode u_decode (
      .addr   (cur.addr),
      .hit    (hit),
      .offset (offset)
   );

   always_comb begin
      sready = 1'b0;
      srdata = '0;
      unique case (1'b1)
         act[SL_BRAM]: begin
            sready = bus.bram_ready;
            srdata = bus.bram_rdata;
         end
         act[SL_UART]: begin
            sready = bus.uart_ready;
            srdata = bus.uart_rdata;
         end
         act[SL_CLINT]: begin
            sready = bus.clint_ready;
            srdata = bus.clint_rdata;
         end
         default: ;
      endcase
   end

   assign tmo = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         pend     <= '0;
         ireq     <= '0;
         dreq     <= '0;
         last     <= PORT_IMEM;
         cur_port <= PORT_IMEM;
         cnt      <= '0;
         act      <= '0;
         s_req    <= '0;
         r_ready  <= 1'b0;
         r_rdata  <= '0;
         r_error  <= 1'b0;
      end else begin
         if (bus.imem_valid && !pend[PORT_IMEM]) begin
            pend[PORT_IMEM] <= 1'b1;
            ireq <= '{instr: 1'b1, addr: bus.imem_addr,
                      wdata: '0, wstrb: '0};
         end
         if (bus.dmem_valid && !pend[PORT_DMEM]) begin
            pend[PORT_DMEM] <= 1'b1;
            dreq <= '{instr: 1'b0, addr: bus.dmem_addr,
                      wdata: bus.dmem_wdata,
                      wstrb: bus.dmem_wstrb};
         end
         unique case (state)
            ST_IDLE: begin
               if (|pend)
                  state <= ST_GRANT;
            end
            ST_GRANT: begin
               cur_port   <= sel;
               last       <= sel;
               pend[sel]  <= 1'b0;
               if (|hit) begin
                  act   <= hit;
                  s_req <= '{instr: cur.instr, addr: offset,
                             wdata: cur.wdata,
                             wstrb: cur.wstrb};
                  cnt   <= '0;
                  state <= ST_WAIT;
               end else begin
                  r_ready <= 1'b1;
                  r_rdata <= '0;
                  r_error <= 1'b1;
                  state   <= ST_RESP;
               end
            end
            ST_WAIT: begin
               if (sready || tmo) begin
                  act     <= '0;
                  s_req   <= '0;
                  r_ready <= 1'b1;
                  r_rdata <= sready ? srdata : '0;
                  r_error <= !sready;
                  state   <= ST_RESP;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_RESP: begin
               r_ready <= 1'b0;
               r_rdata <= '0;
               r_error <= 1'b0;
               state   <= (|pend) ? ST_GRANT : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign i_rsp = r_ready && (cur_port == PORT_IMEM);
   assign d_rsp = r_ready && (cur_port == PORT_DMEM);

   assign bus.imem_ready = i_rsp;
   assign bus.imem_rdata = i_rsp ? r_rdata : '0;
   assign bus.imem_error = i_rsp && r_error;
   assign bus.dmem_ready = d_rsp;
   assign bus.dmem_rdata = d_rsp ? r_rdata : '0;
   assign bus.dmem_error = d_rsp && r_error;

   assign bus.bram_valid  = act[SL_BRAM];
   assign bus.bram_instr  = act[SL_BRAM] && s_req.instr;
   assign bus.bram_addr   = act[SL_BRAM] ? s_req.addr : '0;
   assign bus.bram_wdata  = act[SL_BRAM] ? s_req.wdata : '0;
   assign bus.bram_wstrb  = act[SL_BRAM] ? s_req.wstrb : '0;

   assign bus.uart_valid  = act[SL_UART];
   assign bus.uart_instr  = act[SL_UART] && s_req.instr;
   assign bus.uart_addr   = act[SL_UART] ? s_req.addr : '0;
   assign bus.uart_wdata  = act[SL_UART] ? s_req.wdata : '0;
   assign bus.uart_wstrb  = act[SL_UART] ? s_req.wstrb : '0;

   assign bus.clint_valid = act[SL_CLINT];
   assign bus.clint_instr = act[SL_CLINT] && s_req.instr;
   assign bus.clint_addr  = act[SL_CLINT] ? s_req.addr : '0;
   assign bus.clint_wdata = act[SL_CLINT] ? s_req.wdata : '0;
   assign bus.clint_wstrb = act[SL_CLINT] ? s_req.wstrb : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with simple
// latency-programmable slave models.
module tb_memory_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   memory_arbiter_if bus();

   memory_arbiter #(.TIMEOUT(8)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int p_cyc = 0;

   int blat = 0, ulat = 0, clat = 0;
   bit ben = 1, uen = 1, cen = 1;
   logic [31:0] brd = '0, urd = '0, crd = '0;
   int bcnt = 0, ucnt = 0, ccnt = 0;

   int i_cnt, d_cnt, i_cyc, d_cyc;
   logic [31:0] i_rdata, d_rdata;
   logic i_err, d_err;
   logic [31:0] b_addr, bi_addr, u_addr, u_wdata, c_addr;
   logic [3:0] u_wstrb;
   logic b_instr;
   int b_hi, u_hi, c_hi;
   int multi = 0;
   int order[$];
   bit pb = 0, pu = 0, pc = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h",
                  tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      bcnt <= bus.bram_valid ? bcnt + 1 : 0;
      ucnt <= bus.uart_valid ? ucnt + 1 : 0;
      ccnt <= bus.clint_valid ? ccnt + 1 : 0;
   end

   assign bus.bram_ready  = bus.bram_valid && ben && bcnt >= blat;
   assign bus.uart_ready  = bus.uart_valid && uen && ucnt >= ulat;
   assign bus.clint_ready = bus.clint_valid && cen && ccnt >= clat;
   assign bus.bram_rdata  = brd;
   assign bus.uart_rdata  = urd;
   assign bus.clint_rdata = crd;

   always @(negedge clk) begin
      if (bus.imem_ready) begin
         i_cnt++; i_cyc = cyc;
         i_rdata = bus.imem_rdata; i_err = bus.imem_error;
      end
      if (bus.dmem_ready) begin
         d_cnt++; d_cyc = cyc;
         d_rdata = bus.dmem_rdata; d_err = bus.dmem_error;
      end
      if (int'(bus.bram_valid) + int'(bus.uart_valid)
          + int'(bus.clint_valid) > 1)
         multi++;
      if (bus.bram_valid) begin
         b_hi++; b_addr = bus.bram_addr;
         b_instr = bus.bram_instr;
         if (bus.bram_instr) bi_addr = bus.bram_addr;
      end
      if (bus.uart_valid) begin
         u_hi++; u_addr = bus.uart_addr;
         u_wdata = bus.uart_wdata; u_wstrb = bus.uart_wstrb;
      end
      if (bus.clint_valid) begin
         c_hi++; c_addr = bus.clint_addr;
      end
      if (bus.bram_valid && !pb) order.push_back(0);
      if (bus.uart_valid && !pu) order.push_back(1);
      if (bus.clint_valid && !pc) order.push_back(2);
      pb = bus.bram_valid;
      pu = bus.uart_valid;
      pc = bus.clint_valid;
   end

   function automatic logic [31:0] outs();
      return bus.imem_rdata | bus.dmem_rdata
         | bus.bram_addr | bus.bram_wdata
         | bus.uart_addr | bus.uart_wdata
         | bus.clint_addr | bus.clint_wdata
         | {20'b0, bus.bram_wstrb, bus.uart_wstrb,
            bus.clint_wstrb}
         | {22'b0, bus.imem_ready, bus.imem_error,
            bus.dmem_ready, bus.dmem_error,
            bus.bram_valid, bus.bram_instr,
            bus.uart_valid, bus.uart_instr,
            bus.clint_valid, bus.clint_instr};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      i_cnt = 0; d_cnt = 0; i_cyc = 0; d_cyc = 0;
      i_rdata = '0; d_rdata = '0; i_err = 0; d_err = 0;
      b_addr = '0; bi_addr = '0; u_addr = '0;
      u_wdata = '0; u_wstrb = '0; c_addr = '0;
      b_instr = 0; b_hi = 0; u_hi = 0; c_hi = 0;
      order.delete();
   endtask

   task automatic pulse(input bit iv,
                        input logic [31:0] ia,
                        input bit dv,
                        input logic [31:0] da,
                        input logic [31:0] dw,
                        input logic [3:0] ds);
      bus.imem_valid = iv;
      bus.imem_addr  = ia;
      bus.dmem_valid = dv;
      bus.dmem_addr  = da;
      bus.dmem_wdata = dw;
      bus.dmem_wstrb = ds;
      p_cyc = cyc;
      tick();
      bus.imem_valid = 0;
      bus.dmem_valid = 0;
   endtask

   task automatic wait_rsp(input bit d, input int n);
      int t = 0;
      while ((d ? d_cnt : i_cnt) < n && t < 300) begin
         tick();
         t++;
      end
      if ((d ? d_cnt : i_cnt) < n)
         chk("rsp_timeout", d ? d_cnt : i_cnt, n);
      tick();
      tick();
   endtask

   function automatic int ord(input int k);
      return (order.size() > k) ? order[k] : -1;
   endfunction

   initial begin
      logic [31:0] first_addr;
      int t;
      bus.imem_valid = 0; bus.imem_addr = '0;
      bus.dmem_valid = 0; bus.dmem_addr = '0;
      bus.dmem_wdata = '0; bus.dmem_wstrb = '0;
      clr();

      // reset state
      repeat (3) tick();
      chk("rst_outs", outs(), 0);
      rst = 0;
      tick();
      chk("post_rst_outs", outs(), 0);

      // simultaneous fetch + uart store: dmem wins first tie
      clr();
      brd = 32'h1234_5678; urd = 32'h0000_0055;
      pulse(1, 32'h100, 1, 32'h0100_0000, 32'hA5, 4'hF);
      wait_rsp(0, 1);
      chk("tie_first", ord(0), 1);
      chk("tie_second", ord(1), 0);
      chk("tie_gap", i_cyc - d_cyc, 3);
      chk("tie_d_rdata", d_rdata, 32'h55);
      chk("tie_i_rdata", i_rdata, 32'h1234_5678);
      chk("tie_u_wdata", u_wdata, 32'hA5);
      chk("tie_u_wstrb", u_wstrb, 4'hF);
      chk("tie_u_addr", u_addr, 0);
      chk("tie_bi_addr", bi_addr, 32'h100);

      // bram read, minimum latency
      clr();
      brd = 32'hDEAD_BEEF;
      pulse(0, 0, 1, 32'h4010, 0, 4'h0);
      wait_rsp(1, 1);
      chk("rd_lat", d_cyc - p_cyc, 4);
      chk("rd_rdata", d_rdata, 32'hDEAD_BEEF);
      chk("rd_err", d_err, 0);
      chk("rd_baddr", b_addr, 32'h4010);
      chk("rd_binstr", b_instr, 0);

      // unmapped address
      clr();
      pulse(0, 0, 1, 32'h0300_0000, 0, 4'h0);
      wait_rsp(1, 1);
      chk("um_err", d_err, 1);
      chk("um_rdata", d_rdata, 0);
      chk("um_valids", b_hi + u_hi + c_hi, 0);
      chk("um_lat", d_cyc - p_cyc, 3);

      // clint never ready: timeout after 8 wait cycles
      clr();
      cen = 0; crd = 32'h7777_0000;
      pulse(0, 0, 1, 32'h0200_0004, 0, 4'h0);
      wait_rsp(1, 1);
      chk("to_hi", c_hi, 8);
      chk("to_err", d_err, 1);
      chk("to_rdata", d_rdata, 0);
      chk("to_caddr", c_addr, 4);
      chk("to_lat", d_cyc - p_cyc, 11);

      // ready on the timeout cycle wins
      clr();
      cen = 1; clat = 7;
      pulse(0, 0, 1, 32'h0200_0008, 0, 4'h0);
      wait_rsp(1, 1);
      chk("tr_hi", c_hi, 8);
      chk("tr_err", d_err, 0);
      chk("tr_rdata", d_rdata, 32'h7777_0000);

      // repeated fetch pulses while dmem busy
      clr();
      blat = 6; brd = 32'h0BAD_F00D;
      pulse(0, 0, 1, 32'h0, 0, 4'h0);
      tick(); tick();
      pulse(1, 32'h104, 0, 0, 0, 4'h0);
      pulse(1, 32'h108, 0, 0, 0, 4'h0);
      t = 0;
      while (!bus.imem_ready && t < 100) begin
         tick();
         t++;
      end
      if (!bus.imem_ready)
         chk("busy_ready_seen", 0, 1);
      first_addr = bi_addr;
      pulse(1, 32'h10C, 0, 0, 0, 4'h0);
      wait_rsp(0, 2);
      repeat (10) tick();
      chk("busy_first", first_addr, 32'h104);
      chk("busy_third", bi_addr, 32'h10C);
      chk("busy_icnt", i_cnt, 2);
      chk("busy_dcnt", d_cnt, 1);

      // reset while waiting on bram
      clr();
      ben = 0; blat = 0;
      pulse(0, 0, 1, 32'h100, 0, 4'h0);
      t = 0;
      while (!bus.bram_valid && t < 20) begin
         tick();
         t++;
      end
      if (!bus.bram_valid)
         chk("mr_wait_seen", 0, 1);
      rst = 1;
      tick();
      chk("mr_outs", outs(), 0);
      rst = 0;
      ben = 1;
      repeat (5) tick();
      chk("mr_no_rsp", i_cnt + d_cnt, 0);
      brd = 32'hCAFE_0001;
      pulse(0, 0, 1, 32'h200, 0, 4'h0);
      wait_rsp(1, 1);
      chk("mr_lat", d_cyc - p_cyc, 4);
      chk("mr_rdata", d_rdata, 32'hCAFE_0001);

      chk("one_slave_valid", multi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
